// File: rtl/font_text_gen_buf.sv
// Text-overlay generator: NUM_ROWS x NUM_COLS 8x16 tile buffer with a blank-synchronised write port.
// Optional cursor blink/inversion is built when FONT_TEXT_CURSOR_EN is defined.
module font_text_gen_buf #(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 32,
  parameter int ROW_W        = 2,
  parameter int COL_W        = 5,
  parameter int ROW0         = 12,
  parameter int COL0         = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             frame_tick,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [6:0]       wr_char,
  input  logic [2:0]       wr_color,
  input  logic             clr_req,
  input  logic [ROW_W-1:0] cur_row,
  input  logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic [2:0]       rgb_text,
  output logic             text_on
);

  localparam int AW = ROW_W + COL_W;

  typedef enum logic [1:0] {IDLE, HOLD, CLEAR} state_t;
  state_t state, state_nx;

  logic [9:0]       mem [0:(1<<AW)-1];
  logic [9:0]       ram_q;
  logic [7:0]       font_q;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [9:0]       wr_data;
  logic             accept;

  logic [ROW_W-1:0] hold_row;
  logic [COL_W-1:0] hold_col;
  logic [6:0]       hold_char;
  logic [2:0]       hold_color;
  logic             hold_in_range;
  logic [ROW_W-1:0] clr_row;
  logic [COL_W-1:0] clr_col;
  logic             clr_last;

  // Region test uses one extra bit so coordinates left of/above the origin go negative, i.e. huge.
  logic [7:0]       tx_full;
  logic [6:0]       ty_full;
  logic             in_region;
  logic [AW-1:0]    rd_addr;
  logic             cur_hit;

  assign tx_full   = {1'b0, pixel_x[9:3]} - 8'(COL0);
  assign ty_full   = {1'b0, pixel_y[9:4]} - 7'(ROW0);
  assign in_region = (32'(tx_full) < NUM_COLS) && (32'(ty_full) < NUM_ROWS);
  assign rd_addr   = {ty_full[ROW_W-1:0], tx_full[COL_W-1:0]};

`ifdef FONT_TEXT_CURSOR_EN
  logic [15:0] blink_cnt;
  logic        blink_vis;

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (frame_tick) begin
      if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
        blink_cnt <= '0;
        blink_vis <= ~blink_vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign cur_hit = blink_vis && (ty_full[ROW_W-1:0] == cur_row) && (tx_full[COL_W-1:0] == cur_col);
`else
  logic unused_cursor;
  assign unused_cursor = ^{cur_row, cur_col, frame_tick};
  assign cur_hit       = 1'b0;
`endif

  // Font ROM contents: 'J' glyph, blank space, and a char-code bar for every other code.
  function automatic logic [7:0] font_word(input logic [10:0] addr);
    logic [6:0] ch;
    logic [3:0] r;
    ch = addr[10:4];
    r  = addr[3:0];
    font_word = 8'h00;
    if (ch == 7'h4A) begin
      case (r)
        4'd2:                      font_word = 8'h1E;
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7: font_word = 8'h0C;
        4'd8, 4'd9, 4'd10:         font_word = 8'hCC;
        4'd11:                     font_word = 8'h78;
        default:                   font_word = 8'h00;
      endcase
    end else if (ch != 7'h20) begin
      font_word = {1'b1, ch};
    end
  endfunction

  // Read and write share one block so a same-address access returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    ram_q <= mem[rd_addr];
  end

  logic [3:0] ylo_d1;
  logic [2:0] xlo_d1, xlo_d2;
  logic       on_d1, on_d2, cur_d1, cur_d2;
  logic [2:0] color_d2;
  logic       font_bit;

  always_ff @(posedge clk) begin
    font_q <= font_word({ram_q[9:3], ylo_d1});
  end

  assign font_bit = font_q[~xlo_d2] ^ cur_d2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ylo_d1   <= '0;
      xlo_d1   <= '0;
      xlo_d2   <= '0;
      on_d1    <= 1'b0;
      on_d2    <= 1'b0;
      cur_d1   <= 1'b0;
      cur_d2   <= 1'b0;
      color_d2 <= '0;
      rgb_text <= '0;
      text_on  <= 1'b0;
    end else begin
      ylo_d1   <= pixel_y[3:0];
      xlo_d1   <= pixel_x[2:0];
      on_d1    <= video_on & in_region;
      cur_d1   <= cur_hit;
      xlo_d2   <= xlo_d1;
      on_d2    <= on_d1;
      cur_d2   <= cur_d1;
      color_d2 <= ram_q[2:0];
      rgb_text <= (on_d2 && font_bit) ? color_d2 : 3'b000;
      text_on  <= on_d2;
    end
  end

  assign hold_in_range = (32'(hold_row) < NUM_ROWS) && (32'(hold_col) < NUM_COLS);
  assign clr_last      = (32'(clr_row) == NUM_ROWS - 1) && (32'(clr_col) == NUM_COLS - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hold_row   <= '0;
      hold_col   <= '0;
      hold_char  <= '0;
      hold_color <= '0;
      clr_row    <= '0;
      clr_col    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        hold_row   <= wr_row;
        hold_col   <= wr_col;
        hold_char  <= wr_char;
        hold_color <= wr_color;
      end
      if (state != CLEAR) begin
        clr_row <= '0;
        clr_col <= '0;
      end else if (32'(clr_col) == NUM_COLS - 1) begin
        clr_col <= '0;
        clr_row <= clr_row + 1'b1;
      end else begin
        clr_col <= clr_col + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = {hold_row, hold_col};
    wr_data  = {hold_char, hold_color};
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
        end else begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            accept   = 1'b1;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (clr_req) begin
          state_nx = CLEAR;
        end else if (!video_on) begin
          wr_en    = hold_in_range;
          state_nx = IDLE;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = {clr_row, clr_col};
        wr_data = {7'h20, 3'b000};
        if (clr_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_font_text_gen_buf.sv
// Directed bench for font_text_gen_buf (row index widened to 3 bits so row 5 is expressible).
module tb_font_text_gen_buf;

  logic       clk = 1'b0;
  logic       reset, video_on, frame_tick, wr_valid, wr_ready, clr_req, busy, text_on;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] wr_row, cur_row;
  logic [4:0] wr_col, cur_col;
  logic [6:0] wr_char;
  logic [2:0] wr_color, rgb_text;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  font_text_gen_buf #(.ROW_W(3)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .wr_col(wr_col), .wr_char(wr_char), .wr_color(wr_color), .clr_req(clr_req),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .rgb_text(rgb_text), .text_on(text_on)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] j_row(input int r);
    case (r)
      2:             return 8'h1E;
      3, 4, 5, 6, 7: return 8'h0C;
      8, 9, 10:      return 8'hCC;
      11:            return 8'h78;
      default:       return 8'h00;
    endcase
  endfunction

  task automatic probe(input int x, input int y);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] r, input logic [4:0] c, input logic [6:0] ch, input logic [2:0] co);
    @(negedge clk);
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_char = ch; wr_color = co;
    #1 chk("wr_ready_accept", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("wr_ready_hold", wr_ready, 0);
  endtask

  task automatic commit_blank();
    @(negedge clk);
    video_on = 1'b0;
    @(negedge clk);
    video_on = 1'b1;
    #1 chk("wr_ready_after_commit", wr_ready, 1);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    for (int g = 0; g < 400; g++) begin
      if (busy) n++;
      else break;
      #1 if (wr_ready) n = 1000;
      @(negedge clk);
    end
    chk(tag, n, 128);
  endtask

  // Samples font row 8 / leftmost pixel of every cell: 'J' lights it, blank does not.
  task automatic scan_all(input int er, input int ec, input logic [2:0] ecol);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) begin
        probe((8 + c) * 8, (12 + r) * 16 + 8);
        chk($sformatf("scan_r%0d_c%0d", r, c), rgb_text, (r == er && c == ec) ? ecol : 3'b000);
      end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; video_on = 1'b0; frame_tick = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
    pixel_x = '0; pixel_y = '0; wr_row = '0; wr_col = '0; wr_char = '0; wr_color = '0;
    cur_row = 3'd1; cur_col = 5'd2;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rgb", rgb_text, 0);
    chk("rst_text_on", text_on, 0);

    // Initialise the buffer from IDLE.
    @(negedge clk); clr_req = 1'b1;
    #1 chk("clr_idle_wr_ready", wr_ready, 0);
    @(negedge clk); clr_req = 1'b0;
    count_busy("clr_idle_busy_cycles");

    // 'J' at (0,0), colour 100, requested while the display is active.
    video_on = 1'b1;
    wr(3'd0, 5'd0, 7'h4A, 3'b100);
    commit_blank();
    for (int ry = 0; ry < 16; ry++)
      for (int rx = 0; rx < 8; rx++) begin
        logic [7:0] w;
        w = j_row(ry);
        probe(64 + rx, 192 + ry);
        chk($sformatf("j_pix_x%0d_y%0d", rx, ry), rgb_text, w[7 - rx] ? 3'b100 : 3'b000);
      end
    chk("j_text_on", text_on, 1);

    // Exactly three cycles from coordinates to output.
    probe(64, 200);
    chk("lat_before", rgb_text, 3'b100);
    @(negedge clk); pixel_x = 10'd63;
    repeat (2) @(negedge clk);
    chk("lat_cycle2_rgb", rgb_text, 3'b100);
    chk("lat_cycle2_on", text_on, 1);
    @(negedge clk);
    chk("lat_cycle3_rgb", rgb_text, 3'b000);
    chk("lat_cycle3_on", text_on, 0);

    // Out-of-range row is handshaken and dropped.
    wr(3'd5, 5'd0, 7'h4A, 3'b111);
    commit_blank();
    scan_all(0, 0, 3'b100);

    // Clear during HOLD discards the pending write.
    wr(3'd1, 5'd3, 7'h4A, 3'b010);
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    count_busy("clr_hold_busy_cycles");
    chk("clr_hold_ready_after", wr_ready, 1);
    scan_all(-1, -1, 3'b000);

    // Clear and write in the same cycle: clear wins, write not accepted.
    @(negedge clk);
    wr_valid = 1'b1; clr_req = 1'b1; wr_row = 3'd2; wr_col = 5'd2; wr_char = 7'h4A; wr_color = 3'b111;
    #1 chk("clr_wr_same_ready", wr_ready, 0);
    @(negedge clk); wr_valid = 1'b0; clr_req = 1'b0;
    count_busy("clr_wr_busy_cycles");
    probe(80, 232);
    chk("clr_wr_not_written", rgb_text, 3'b000);

    // Region boundaries.
    probe(63, 192);  chk("edge_x63", text_on, 0);
    probe(320, 192); chk("edge_x320", text_on, 0);
    probe(64, 191);  chk("edge_y191", text_on, 0);
    probe(64, 256);  chk("edge_y256", text_on, 0);
    probe(319, 255); chk("edge_last_in", text_on, 1);
    @(negedge clk); pixel_x = 10'd64; pixel_y = 10'd192; video_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("video_off_text_on", text_on, 0);

    // Cursor cell (1,2): blank glyph with colour 101.
    video_on = 1'b1;
    wr(3'd1, 5'd2, 7'h20, 3'b101);
    commit_blank();
`ifdef FONT_TEXT_CURSOR_EN
    probe(80, 208); chk("cur_tick0", rgb_text, 3'b101);
    ticks(29);
    probe(80, 208); chk("cur_tick29", rgb_text, 3'b101);
    ticks(1);
    probe(80, 208); chk("cur_tick30", rgb_text, 3'b000);
    ticks(29);
    probe(80, 208); chk("cur_tick59", rgb_text, 3'b000);
    ticks(1);
    probe(80, 208); chk("cur_tick60", rgb_text, 3'b101);
    probe(88, 208); chk("cur_neighbour", rgb_text, 3'b000);
`else
    probe(80, 208); chk("nocur_tick0", rgb_text, 3'b000);
    ticks(30);
    probe(80, 208); chk("nocur_tick30", rgb_text, 3'b000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/font_text_gen_buf.md
Name: font_text_gen_buf

Overview:
Parametrised text-overlay generator for the VGA path: a character/attribute buffer of NUM_ROWS x NUM_COLS 8x16 tiles, drawn at a configurable tile origin. Each cell stores a 7-bit ASCII code and a 3-bit colour. Writes arrive through a valid/ready port and are committed only during blanking, so the picture never tears. It replaces fixed-string text generation, sits between the sync/pixel counter and the RGB mux, and uses the existing 1-cycle font ROM (11-bit addr = {char, row}).

Parameters:
NUM_ROWS, 4, number of text rows in the buffer
NUM_COLS, 32, number of text columns in the buffer
ROW_W, 2, width of the row index (>= clog2(NUM_ROWS))
COL_W, 5, width of the column index (>= clog2(NUM_COLS))
ROW0, 12, tile row (pixel_y[9:4]) of buffer row 0
COL0, 8, tile column (pixel_x[9:3]) of buffer column 0
BLINK_FRAMES, 30, frames per cursor half-period

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-low reset
video_on  in  1  active display area
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
frame_tick  in  1  one-cycle pulse per frame
wr_valid  in  1  write request
wr_ready  out  1  buffer can accept a write
wr_row  in  ROW_W  target row
wr_col  in  COL_W  target column
wr_char  in  7  ASCII code
wr_color  in  3  RGB attribute
clr_req  in  1  pulse: clear all cells
cur_row  in  ROW_W  cursor row
cur_col  in  COL_W  cursor column
busy  out  1  clear in progress
rgb_text  out  3  text pixel colour, 0 = transparent
text_on  out  1  pixel lies in the text region

Behaviour:
- Clock is clk. Reset is synchronous and active-low. Reset values: rgb_text=0, text_on=0, wr_ready=1, busy=0, FSM=IDLE, blink counter=0, blink phase=visible. Buffer RAM contents are not reset.
- Region: tx=pixel_x[9:3]-COL0, ty=pixel_y[9:4]-ROW0. The pixel is in the region when 0<=tx<NUM_COLS and 0<=ty<NUM_ROWS, using unsigned compare on the full difference. No wrap-around: pixels left of or above the origin are outside the region.
- Pipeline, fixed latency 3 cycles from pixel_x/pixel_y/video_on to rgb_text/text_on:
  - S0: RAM read address {ty,tx}.
  - S1: RAM data valid; font ROM address = {char, pixel_y[3:0] delayed 1}.
  - S2: font word valid. Bit pixel_x[2:0] (delayed 2) selects the font bit, MSB is leftmost.
  - S3: output registers update.
- Output: rgb_text = color when video_on & region & font_bit, else 0. text_on = video_on & region, all values delayed to align with the S3 output.
- Cursor: at cell (cur_row, cur_col), when the blink phase is visible, the cell's bits are inverted (font_bit XOR 1). The blink counter counts frame_tick pulses. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
- FSM states: IDLE, HOLD, CLEAR.
  - IDLE: wr_ready=1. On wr_valid, capture row/col/char/color into the hold register and go to HOLD. If clr_req and wr_valid occur in the same cycle, clr_req wins: the write is not accepted (wr_ready=0 that cycle) and the FSM goes to CLEAR.
  - HOLD: wr_ready=0. On the first cycle with video_on=0, commit the write to RAM and return to IDLE. An out-of-range row/col is dropped at commit, with no RAM write. A clr_req in HOLD discards the pending write and goes to CLEAR.
  - CLEAR: busy=1, wr_ready=0. Writes char 0x20 / color 0 to one cell per cycle, linear index 0..NUM_ROWS*NUM_COLS-1 (128 cycles at default). Writes ignore video_on, so brief tearing is accepted. Return to IDLE on the cycle after the last cell. clr_req during CLEAR is ignored.
- The RAM is simple dual-port: one write port (FSM) and one read port (display). A read and a write to the same address in the same cycle return the old data.
- Reset mid-CLEAR or mid-HOLD aborts the operation. Cells already written keep their values.

Optional Feature:
FONT_TEXT_CURSOR_EN.
- Defined: cursor inversion and the blink counter are present as described above.
- Undefined: cur_row, cur_col and frame_tick are ignored, no blink logic is synthesised, and cells are drawn with no inversion.

Test Plan:
1. Reset, then idle 10 cycles -> wr_ready=1, busy=0, rgb_text=0, text_on=0.
2. Write row 0, col 0, char 0x4A ('J'), color 3'b100 while video_on=1 -> wr_ready=0 until the first video_on=0 cycle, then commit. On the next frame, the pixel at (64,192) shows rgb_text=3'b100 exactly where the 'J' font bits are 1, 3 cycles after the coordinates.
3. Write to row 5 (out of range) -> handshake completes and no RAM cell changes; a readback scan of all 128 cells matches the prior contents.
4. Pulse clr_req during HOLD -> the pending write is discarded, busy=1 for exactly 128 cycles, and every cell then reads 0x20 with rgb_text=0 across the region.
5. Drive pixel_x=63 and pixel_x=320 on row y=192 -> text_on=0 (outside the region). Drive pixel_y=191 -> text_on=0.
6. With FONT_TEXT_CURSOR_EN defined, cursor at (1,2), 60 frame_ticks -> the cell is inverted for ticks 0-29, normal for ticks 30-59, and inverted again at tick 60.
